// File: rtl/proj_pkg.sv
// ---------------------------------------------------------------------------
// proj_pkg
// Shared definitions for the FM buffer datapath.
//   FM_BUFFER_SIZE : entries held by one FM buffer
//   HASH_WIDTH     : width of one stored hash, bits
//   rd_state_t     : buffer-reader FSM encoding, also decoded by the
//                    sort/control FSM for debug visibility
// ---------------------------------------------------------------------------
package proj_pkg;

   localparam int FM_BUFFER_SIZE = 8;
   localparam int HASH_WIDTH     = 16;

   typedef enum logic [2:0] {
      RD_IDLE,
      RD_FETCH,
      RD_LOAD,
      RD_PRESENT,
      RD_DONE
   } rd_state_t;

endpackage

// File: rtl/proj_buffer_reader_min_tracker.sv
// ---------------------------------------------------------------------------
// proj_min_tracker
// Running minimum register with its index. Also reused by the signature
// combiner.
//   clk, rst     : clock, asynchronous active-high reset (clears min/index)
//   clear_i      : zero the running min and index
//   load_i       : take hash_i/index_i unconditionally (first entry)
//   cmp_i        : take hash_i/index_i only if hash_i is strictly smaller
//   hash_i       : candidate hash (unsigned)
//   index_i      : candidate index
//   min_hash_o   : current running minimum
//   min_index_o  : index of current running minimum
// ---------------------------------------------------------------------------
module proj_min_tracker #(
   parameter int HASH_WIDTH = 16,
   parameter int IDX_W      = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear_i,
   input  logic                  load_i,
   input  logic                  cmp_i,
   input  logic [HASH_WIDTH-1:0] hash_i,
   input  logic [IDX_W-1:0]      index_i,
   output logic [HASH_WIDTH-1:0] min_hash_o,
   output logic [IDX_W-1:0]      min_index_o
);

   logic [HASH_WIDTH-1:0] min_hash_q, min_hash_d;
   logic [IDX_W-1:0]      min_index_q, min_index_d;

   // Strict less-than so that ties keep the earlier (lower) index.
   always_comb begin
      min_hash_d  = min_hash_q;
      min_index_d = min_index_q;
      if (clear_i) begin
         min_hash_d  = '0;
         min_index_d = '0;
      end else if (load_i || (cmp_i && (hash_i < min_hash_q))) begin
         min_hash_d  = hash_i;
         min_index_d = index_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         min_hash_q  <= '0;
         min_index_q <= '0;
      end else begin
         min_hash_q  <= min_hash_d;
         min_index_q <= min_index_d;
      end
   end

   assign min_hash_o  = min_hash_q;
   assign min_index_o = min_index_q;

endmodule

// File: rtl/proj_buffer_reader.sv
// ---------------------------------------------------------------------------
// proj_buffer_reader
// Read-side partner of the FM buffer write counter. After start, walks
// addresses 0..FM_BUFFER_SIZE-1 through the buffer's synchronous read port,
// streams every entry over valid/ready, and reduces the pass to its minimum
// hash and that entry's index, announced with a one-cycle done pulse.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : buffer full, begin a read pass (ignored while busy)
//   rd_en      : read strobe to buffer memory (FETCH only)
//   rd_addr    : read address to buffer memory
//   rd_data    : memory data, valid the cycle after rd_en
//   out_valid  : stream valid
//   out_ready  : stream ready from consumer
//   out_data   : stream hash value
//   out_index  : stream buffer address of out_data
//   out_last   : stream final-entry qualifier
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse, min_hash/min_index just updated
//   min_hash   : minimum hash of the last completed pass
//   min_index  : index of min_hash
// ---------------------------------------------------------------------------
module proj_buffer_reader import proj_pkg::*; #(
   parameter int FM_BUFFER_SIZE = proj_pkg::FM_BUFFER_SIZE,
   parameter int HASH_WIDTH     = proj_pkg::HASH_WIDTH,
   parameter int ADDR_W         = $clog2(FM_BUFFER_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  rd_en,
   output logic [ADDR_W-1:0]     rd_addr,
   input  logic [HASH_WIDTH-1:0] rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [HASH_WIDTH-1:0] out_data,
   output logic [ADDR_W-1:0]     out_index,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done,
   output logic [HASH_WIDTH-1:0] min_hash,
   output logic [ADDR_W-1:0]     min_index
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FM_BUFFER_SIZE - 1);

   rd_state_t             state_q;
   logic [ADDR_W-1:0]     addr_q;
   logic                  rd_en_q;
   logic                  out_valid_q;
   logic [HASH_WIDTH-1:0] out_data_q;
   logic                  out_last_q;
   logic                  busy_q;
   logic                  done_q;
   logic [HASH_WIDTH-1:0] min_hash_q;
   logic [ADDR_W-1:0]     min_index_q;

   logic [HASH_WIDTH-1:0] trk_hash;
   logic [ADDR_W-1:0]     trk_index;
   logic                  trk_clear, trk_load, trk_cmp;

   // The tracker sees rd_data in LOAD, the same cycle it lands in the hold
   // register; index 0 seeds the minimum so no stale value can win.
   assign trk_clear = (state_q == RD_IDLE) && start;
   assign trk_load  = (state_q == RD_LOAD) && (addr_q == '0);
   assign trk_cmp   = (state_q == RD_LOAD) && (addr_q != '0);

   proj_min_tracker #(
      .HASH_WIDTH (HASH_WIDTH),
      .IDX_W      (ADDR_W)
   ) u_min_tracker (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (trk_clear),
      .load_i      (trk_load),
      .cmp_i       (trk_cmp),
      .hash_i      (rd_data),
      .index_i     (addr_q),
      .min_hash_o  (trk_hash),
      .min_index_o (trk_index)
   );

   // All outputs are registered; each is set on the edge entering the state
   // in which it must be visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RD_IDLE;
         addr_q      <= '0;
         rd_en_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         min_hash_q  <= '0;
         min_index_q <= '0;
      end else begin
         rd_en_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            RD_IDLE: begin
               if (start) begin
                  state_q <= RD_FETCH;
                  rd_en_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            RD_FETCH: begin
               state_q <= RD_LOAD;
            end
            RD_LOAD: begin
               out_data_q  <= rd_data;
               out_last_q  <= (addr_q == LAST_ADDR);
               out_valid_q <= 1'b1;
               state_q     <= RD_PRESENT;
            end
            RD_PRESENT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  if (addr_q == LAST_ADDR) begin
                     state_q     <= RD_DONE;
                     done_q      <= 1'b1;
                     min_hash_q  <= trk_hash;
                     min_index_q <= trk_index;
                  end else begin
                     addr_q  <= addr_q + ADDR_W'(1);
                     rd_en_q <= 1'b1;
                     state_q <= RD_FETCH;
                  end
               end
            end
            RD_DONE: begin
               state_q <= RD_IDLE;
               addr_q  <= '0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= RD_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // The counter only moves on acceptance, so it doubles as read address
   // and as the index of the entry being presented.
   assign rd_en     = rd_en_q;
   assign rd_addr   = addr_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_index = addr_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign min_hash  = min_hash_q;
   assign min_index = min_index_q;

endmodule

// File: tb/tb_proj_buffer_reader.sv
module tb_proj_buffer_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        out_ready;
   logic        rd_en;
   logic [2:0]  rd_addr;
   logic [15:0] rd_data = '0;
   logic        out_valid;
   logic [15:0] out_data;
   logic [2:0]  out_index;
   logic        out_last;
   logic        busy;
   logic        done;
   logic [15:0] min_hash;
   logic [2:0]  min_index;

   logic [15:0] mem [0:7];

   int errors = 0;
   int checks = 0;

   // Pass observations
   int          beats, dones, first_valid, done_cyc, stall_viol, stall_cnt;
   int          minchg, rdcnt, addr_viol;
   logic [15:0] bdata [0:15];
   int          bidx  [0:15];
   logic        blast [0:15];
   logic [15:0] dmin_h, pre_h;
   logic [2:0]  dmin_i, pre_i;

   proj_buffer_reader dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .min_hash  (min_hash),
      .min_index (min_index)
   );

   always #5 clk = ~clk;

   // Synchronous-read buffer memory, one cycle latency
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   task automatic load_image_a();
      for (int i = 0; i < 8; i++) mem[i] = 16'(100 - i);
   endtask

   // Drives one pass from the current negedge and records what the DUT does.
   task automatic run_pass(input int stall_idx, input int stall_len,
                           input bit mid_start, input bit start_in_done);
      logic [15:0] held;
      bit          seen;
      held = '0; seen = 1'b0;
      beats = 0; dones = 0; first_valid = -1; done_cyc = -1; stall_viol = 0;
      stall_cnt = 0; minchg = 0; rdcnt = 0; addr_viol = 0;
      pre_h = min_hash; pre_i = min_index;
      out_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      for (int cyc = 1; cyc <= 300; cyc++) begin
         start = 1'b0;
         out_ready = 1'b1;
         if (mid_start && cyc == 10) start = 1'b1;
         if (rd_en) begin
            rdcnt++;
            if (int'(rd_addr) != beats) addr_viol++;
         end
         if (out_valid) begin
            if (first_valid < 0) first_valid = cyc;
            if (int'(out_index) == stall_idx && stall_cnt < stall_len) begin
               out_ready = 1'b0;
               if (stall_cnt == 0) held = out_data;
               else if (out_data !== held) stall_viol++;
               if (rd_en !== 1'b0) stall_viol++;
               stall_cnt++;
            end else begin
               if (beats < 16) begin
                  bdata[beats] = out_data;
                  bidx[beats]  = int'(out_index);
                  blast[beats] = out_last;
               end
               beats++;
            end
         end
         if (!done && !seen && (min_hash !== pre_h || min_index !== pre_i)) minchg++;
         if (done) begin
            dones++;
            if (done_cyc < 0) done_cyc = cyc;
            dmin_h = min_hash;
            dmin_i = min_index;
            seen = 1'b1;
            if (start_in_done) start = 1'b1;
         end else if (seen) begin
            break;
         end
         @(negedge clk);
      end
      start = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++; if (rd_en !== 1'b0)       begin errors++; $display("FAIL reset_rd_en got=%0b want=0", rd_en); end
      checks++; if (rd_addr !== 3'd0)     begin errors++; $display("FAIL reset_rd_addr got=%0d want=0", rd_addr); end
      checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
      checks++; if (out_data !== 16'd0)   begin errors++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
      checks++; if (out_last !== 1'b0)    begin errors++; $display("FAIL reset_out_last got=%0b want=0", out_last); end
      checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got=%0b want=0", busy); end
      checks++; if (done !== 1'b0)        begin errors++; $display("FAIL reset_done got=%0b want=0", done); end
      checks++; if (min_hash !== 16'd0)   begin errors++; $display("FAIL reset_min_hash got=%0d want=0", min_hash); end
      checks++; if (min_index !== 3'd0)   begin errors++; $display("FAIL reset_min_index got=%0d want=0", min_index); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic_pass();
      load_image_a();
      run_pass(-1, 0, 1'b0, 1'b0);
      checks++; if (beats != 8)       begin errors++; $display("FAIL basic_beats got=%0d want=8", beats); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (bidx[i] != i)   begin errors++; $display("FAIL basic_index[%0d] got=%0d want=%0d", i, bidx[i], i); end
         checks++; if (bdata[i] !== 16'(100 - i)) begin errors++; $display("FAIL basic_data[%0d] got=%0d want=%0d", i, bdata[i], 100 - i); end
         checks++; if (blast[i] !== (i == 7)) begin errors++; $display("FAIL basic_last[%0d] got=%0b want=%0b", i, blast[i], (i == 7)); end
      end
      checks++; if (first_valid != 3) begin errors++; $display("FAIL basic_latency got=%0d want=3", first_valid); end
      checks++; if (done_cyc != 25)   begin errors++; $display("FAIL basic_done_cycle got=%0d want=25", done_cyc); end
      checks++; if (dones != 1)       begin errors++; $display("FAIL basic_done_count got=%0d want=1", dones); end
      checks++; if (rdcnt != 8)       begin errors++; $display("FAIL basic_rd_en_cycles got=%0d want=8", rdcnt); end
      checks++; if (addr_viol != 0)   begin errors++; $display("FAIL basic_rd_addr_order got=%0d want=0", addr_viol); end
      checks++; if (dmin_h !== 16'd93) begin errors++; $display("FAIL basic_min_hash got=%0d want=93", dmin_h); end
      checks++; if (dmin_i !== 3'd7)  begin errors++; $display("FAIL basic_min_index got=%0d want=7", dmin_i); end
      checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL basic_busy_after got=%0b want=0", busy); end
   endtask

   task automatic test_tie();
      for (int i = 0; i < 8; i++) mem[i] = 16'd5;
      mem[3] = 16'd2;
      mem[6] = 16'd2;
      run_pass(-1, 0, 1'b0, 1'b0);
      checks++; if (dmin_h !== 16'd2) begin errors++; $display("FAIL tie_min_hash got=%0d want=2", dmin_h); end
      checks++; if (dmin_i !== 3'd3)  begin errors++; $display("FAIL tie_min_index got=%0d want=3", dmin_i); end
      checks++; if (bdata[6] !== 16'd2) begin errors++; $display("FAIL tie_data6 got=%0d want=2", bdata[6]); end
   endtask

   task automatic test_backpressure();
      load_image_a();
      run_pass(2, 4, 1'b0, 1'b0);
      checks++; if (stall_cnt != 4)   begin errors++; $display("FAIL bp_held_cycles got=%0d want=4", stall_cnt); end
      checks++; if (stall_viol != 0)  begin errors++; $display("FAIL bp_stable_no_rd got=%0d want=0", stall_viol); end
      checks++; if (beats != 8)       begin errors++; $display("FAIL bp_beats got=%0d want=8", beats); end
      checks++; if (bidx[2] != 2 || bdata[2] !== 16'd98) begin errors++; $display("FAIL bp_beat2 got=%0d/%0d want=2/98", bidx[2], bdata[2]); end
      checks++; if (bidx[3] != 3 || bdata[3] !== 16'd97) begin errors++; $display("FAIL bp_beat3 got=%0d/%0d want=3/97", bidx[3], bdata[3]); end
      checks++; if (done_cyc != 29)   begin errors++; $display("FAIL bp_done_cycle got=%0d want=29", done_cyc); end
      checks++; if (dmin_h !== 16'd93 || dmin_i !== 3'd7) begin errors++; $display("FAIL bp_min got=%0d/%0d want=93/7", dmin_h, dmin_i); end
   endtask

   task automatic test_start_ignored();
      load_image_a();
      run_pass(-1, 0, 1'b1, 1'b1);
      checks++; if (dones != 1)       begin errors++; $display("FAIL ign_done_count got=%0d want=1", dones); end
      checks++; if (beats != 8)       begin errors++; $display("FAIL ign_beats got=%0d want=8", beats); end
      checks++; if (done_cyc != 25)   begin errors++; $display("FAIL ign_done_cycle got=%0d want=25", done_cyc); end
      checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL ign_done_start_busy got=%0b want=0", busy); end
      // start issued right after the done cycle begins a fresh pass
      run_pass(-1, 0, 1'b0, 1'b0);
      checks++; if (first_valid != 3) begin errors++; $display("FAIL ign_restart_latency got=%0d want=3", first_valid); end
      checks++; if (dones != 1 || beats != 8) begin errors++; $display("FAIL ign_restart_pass got=%0d/%0d want=1/8", dones, beats); end
   endtask

   task automatic test_async_reset();
      int guard;
      bit stray_done;
      load_image_a();
      guard = 0;
      stray_done = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!(out_valid === 1'b1 && out_index === 3'd2) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checks++; if (guard >= 100) begin errors++; $display("FAIL arst_reach_present got=timeout want=index2"); end
      #2 rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0)
         begin errors++; $display("FAIL arst_ctrl got=v%0b b%0b r%0b want=0", out_valid, busy, rd_en); end
      checks++; if (out_data !== 16'd0 || out_index !== 3'd0 || rd_addr !== 3'd0)
         begin errors++; $display("FAIL arst_data got=%0d/%0d/%0d want=0", out_data, out_index, rd_addr); end
      checks++; if (min_hash !== 16'd0 || min_index !== 3'd0)
         begin errors++; $display("FAIL arst_min got=%0d/%0d want=0", min_hash, min_index); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done !== 1'b0) stray_done = 1'b1;
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done !== 1'b0) stray_done = 1'b1;
      end
      checks++; if (stray_done) begin errors++; $display("FAIL arst_no_done got=1 want=0"); end
      run_pass(-1, 0, 1'b0, 1'b0);
      checks++; if (beats != 8 || bidx[0] != 0 || bdata[0] !== 16'd100)
         begin errors++; $display("FAIL arst_clean_pass got=%0d/%0d/%0d want=8/0/100", beats, bidx[0], bdata[0]); end
      checks++; if (dmin_h !== 16'd93 || dmin_i !== 3'd7) begin errors++; $display("FAIL arst_min_after got=%0d/%0d want=93/7", dmin_h, dmin_i); end
   endtask

   task automatic test_back_to_back();
      mem[0] = 16'd40; mem[1] = 16'd30; mem[2] = 16'd35; mem[3] = 16'd20;
      mem[4] = 16'd25; mem[5] = 16'd50; mem[6] = 16'd20; mem[7] = 16'd60;
      run_pass(-1, 0, 1'b0, 1'b0);
      checks++; if (pre_h !== 16'd93 || pre_i !== 3'd7) begin errors++; $display("FAIL b2b_old_min got=%0d/%0d want=93/7", pre_h, pre_i); end
      checks++; if (minchg != 0)      begin errors++; $display("FAIL b2b_min_held got=%0d want=0", minchg); end
      checks++; if (dmin_h !== 16'd20 || dmin_i !== 3'd3) begin errors++; $display("FAIL b2b_new_min got=%0d/%0d want=20/3", dmin_h, dmin_i); end
      @(negedge clk);
      checks++; if (min_hash !== 16'd20 || min_index !== 3'd3) begin errors++; $display("FAIL b2b_min_hold got=%0d/%0d want=20/3", min_hash, min_index); end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) mem[i] = '0;
      test_reset();
      test_basic_pass();
      test_tie();
      test_backpressure();
      test_start_ignored();
      test_async_reset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
